// File: rtl/gfx_pkg.sv
// Shared graphics types and defaults for the framebuffer write path.
package gfx_pkg;

    localparam int GFX_FB_WIDTH  = 320;
    localparam int GFX_FB_HEIGHT = 180;
    localparam int GFX_ADDRW     = 16;
    localparam int GFX_COLRW     = 4;

    // One framebuffer write: linear pixel address plus colour index.
    typedef struct packed {
        logic [GFX_ADDRW-1:0] addr;
        logic [GFX_COLRW-1:0] colr;
    } fb_wr_t;

    // Shape tracking states for framebuffer writers.
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN,
        DONE
    } fb_wr_state_t;

    // True when a width x height framebuffer is addressable with addrw bits.
    function automatic bit fbFits(input int width, input int height, input int addrw);
        return (longint'(width) * longint'(height)) <= (longint'(1) << addrw);
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with registered occupancy count and full/empty flags.
// Push while full is accepted only when a pop frees a slot in the same cycle.
// Push into an empty FIFO becomes visible on the output the following cycle.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depthCheck
        $error("fifo_sync: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    // Storage array; no reset needed since reads are qualified by the count.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/draw_fb_writer.sv
// Framebuffer writer sitting behind a pixel drawer.
// Clips each drawn pixel, turns it into a linear address, queues it, and
// issues it to the framebuffer under a ready handshake. The drawer is
// throttled through oe, and done fires only after every pixel is committed.
module draw_fb_writer
    import gfx_pkg::*;
#(
    parameter int CORDW      = 16,
    parameter int FB_WIDTH   = GFX_FB_WIDTH,
    parameter int FB_HEIGHT  = GFX_FB_HEIGHT,
    parameter int ADDRW      = GFX_ADDRW,
    parameter int COLRW      = GFX_COLRW,
    parameter int FIFO_DEPTH = 8,
    parameter int OE_SLACK   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [COLRW-1:0]        colr,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic                    drawing,
    input  logic                    draw_busy,
    input  logic                    draw_done,
    output logic                    oe,
    output logic                    fb_we,
    input  logic                    fb_ready,
    output logic [ADDRW-1:0]        fb_addr,
    output logic [COLRW-1:0]        fb_colr,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int MW = CW + 8;

    localparam logic signed [CORDW-1:0] X_LIMIT = CORDW'(FB_WIDTH);
    localparam logic signed [CORDW-1:0] Y_LIMIT = CORDW'(FB_HEIGHT);

    if (!fbFits(FB_WIDTH, FB_HEIGHT, ADDRW)) begin : g_addrwCheck
        $error("draw_fb_writer: FB_WIDTH*FB_HEIGHT does not fit in ADDRW bits");
    end

    if (ADDRW != GFX_ADDRW || COLRW != GFX_COLRW) begin : g_structCheck
        $error("draw_fb_writer: ADDRW/COLRW must match the shared fb_wr_t layout");
    end

    if (FIFO_DEPTH < 4) begin : g_depthCheck
        $error("draw_fb_writer: FIFO_DEPTH must be at least 4");
    end

    if (FB_WIDTH >= (1 << (CORDW-1)) || FB_HEIGHT >= (1 << (CORDW-1))) begin : g_cordCheck
        $error("draw_fb_writer: framebuffer size exceeds signed coordinate range");
    end

    // Stage 1 registers
    logic                    r_s1Valid;
    logic signed [CORDW-1:0] r_s1X;
    logic signed [CORDW-1:0] r_s1Y;
    logic [COLRW-1:0]        r_s1Colr;

    // Stage 2 registers
    logic   r_s2Valid;
    fb_wr_t r_s2Entry;

    // Throttle and error state
    logic r_oe;
    logic r_overflow;

    // Control FSM
    fb_wr_state_t r_state;
    fb_wr_state_t w_stateNext;

    logic             w_inBounds;
    logic [ADDRW-1:0] w_s1Addr;
    logic             w_fifoFull;
    logic             w_fifoEmpty;
    logic [CW-1:0]    w_fifoCount;
    logic [CW-1:0]    w_freeEntries;
    logic [1:0]       w_pipeCount;
    logic [MW-1:0]    w_freeExt;
    logic [MW-1:0]    w_needExt;
    logic             w_oeNext;
    logic             w_pop;
    logic             w_drop;
    logic             w_pipeBusy;
    logic             w_done;
    fb_wr_t           w_head;

    // Pixel lies on the framebuffer: both coordinates non-negative and below the limits.
    assign w_inBounds = drawing
                     && !x[CORDW-1] && (x < X_LIMIT)
                     && !y[CORDW-1] && (y < Y_LIMIT);

    // Linear address of the stage-1 pixel; coordinates are known non-negative here.
    assign w_s1Addr = ADDRW'(r_s1Y) * ADDRW'(FB_WIDTH) + ADDRW'(r_s1X);

    // Stage 1: capture clipped pixel coordinates and colour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1X     <= '0;
            r_s1Y     <= '0;
            r_s1Colr  <= '0;
        end else begin
            r_s1Valid <= w_inBounds;
            r_s1X     <= x;
            r_s1Y     <= y;
            r_s1Colr  <= colr;
        end
    end

    // Stage 2: register the linear address ready for the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2Valid <= 1'b0;
            r_s2Entry <= '0;
        end else begin
            r_s2Valid      <= r_s1Valid;
            r_s2Entry.addr <= w_s1Addr;
            r_s2Entry.colr <= r_s1Colr;
        end
    end

    assign w_pop = !w_fifoEmpty && fb_ready;

    fifo_sync #(
        .WIDTH ($bits(fb_wr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_s2Valid),
        .i_data  (r_s2Entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_count (w_fifoCount)
    );

    // Room left after the pixels already in flight must exceed what the drawer
    // can still emit once oe falls.
    assign w_freeEntries = CW'(FIFO_DEPTH) - w_fifoCount;
    assign w_pipeCount   = {1'b0, r_s1Valid} + {1'b0, r_s2Valid};
    assign w_freeExt     = MW'(w_freeEntries);
    assign w_needExt     = MW'(w_pipeCount) + MW'(OE_SLACK);
    assign w_oeNext      = (w_freeExt > w_needExt);

    assign w_drop     = r_s2Valid && w_fifoFull && !w_pop;
    assign w_pipeBusy = r_s1Valid || r_s2Valid;

    // Registered output enable back to the drawer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_oe <= 1'b1;
        end else begin
            r_oe <= w_oeNext;
        end
    end

    // Sticky flag for any pixel lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Shape-tracking state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and done decode; done waits until pipeline and FIFO are both empty.
    always_comb begin
        w_stateNext = r_state;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (draw_busy && draw_done) begin
                    w_stateNext = DRAIN;
                end else if (draw_busy) begin
                    w_stateNext = ACTIVE;
                end
            end
            ACTIVE: begin
                if (draw_done) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (!w_pipeBusy && w_fifoEmpty) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Framebuffer port driven from the FIFO head; zero while nothing is pending.
    always_comb begin
        fb_we   = !w_fifoEmpty;
        fb_addr = '0;
        fb_colr = '0;
        if (!w_fifoEmpty) begin
            fb_addr = w_head.addr;
            fb_colr = w_head.colr;
        end
    end

    assign oe       = r_oe;
    assign overflow = r_overflow;
    assign done     = w_done;
    assign busy     = (r_state != IDLE) || !w_fifoEmpty || w_pipeBusy;

endmodule

// File: tb/tb_draw_fb_writer.sv
// Testbench for draw_fb_writer: clipping/address table, latency, throttling,
// overflow and mid-shape reset, with a scoreboard checking every framebuffer write.
module tb_draw_fb_writer;

    localparam int CORDW = 16;
    localparam int ADDRW = 16;
    localparam int COLRW = 4;

    logic                    clk = 1'b0;
    logic                    rstN;
    logic [COLRW-1:0]        colr;
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic                    drawing;
    logic                    drawBusy;
    logic                    drawDone;
    logic                    oe;
    logic                    fbWe;
    logic                    fbReady;
    logic [ADDRW-1:0]        fbAddr;
    logic [COLRW-1:0]        fbColr;
    logic                    busy;
    logic                    done;
    logic                    overflow;

    typedef struct {
        int addr;
        int colr;
    } expWrite_t;

    typedef struct {
        int px;
        int py;
        int pc;
        bit expWr;
        int expAddr;
    } vector_t;

    expWrite_t expQ[$];
    int checks     = 0;
    int errors     = 0;
    int writeCount = 0;

    draw_fb_writer #(
        .CORDW      (CORDW),
        .FB_WIDTH   (320),
        .FB_HEIGHT  (180),
        .ADDRW      (ADDRW),
        .COLRW      (COLRW),
        .FIFO_DEPTH (8),
        .OE_SLACK   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .colr      (colr),
        .x         (x),
        .y         (y),
        .drawing   (drawing),
        .draw_busy (drawBusy),
        .draw_done (drawDone),
        .oe        (oe),
        .fb_we     (fbWe),
        .fb_ready  (fbReady),
        .fb_addr   (fbAddr),
        .fb_colr   (fbColr),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Compare one value and report a mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Move to the drive point just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel for one cycle and record the write it should produce
    task automatic applyStimulus(input int px, input int py, input int pc, input bit expWr, input int expAddr);
        expWrite_t e;
        x       = 16'(px);
        y       = 16'(py);
        colr    = 4'(pc);
        drawing = 1'b1;
        if (expWr) begin
            e.addr = expAddr;
            e.colr = pc;
            expQ.push_back(e);
        end
        tick();
    endtask

    // Watch a fixed window for exactly one done pulse and a quiet writer
    task automatic waitForDone(input string name);
        int pulses;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput({name, "DonePulses"}, 32'(pulses), 32'd1);
        checkOutput({name, "BusyIdle"}, 32'(busy), 32'd0);
        checkOutput({name, "QueueEmpty"}, 32'(expQ.size()), 32'd0);
        tick();
    endtask

    // End the current shape with a draw_done pulse
    task automatic finishShape(input string name);
        drawing  = 1'b0;
        drawBusy = 1'b0;
        drawDone = 1'b1;
        tick();
        drawDone = 1'b0;
        waitForDone(name);
    endtask

    // Scoreboard: every committed write must match the oldest expectation
    always @(negedge clk) begin
        if (rstN && fbWe && fbReady) begin
            writeCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedWrite: actual addr=%0d colr=%0d required=no write", fbAddr, fbColr);
            end else begin
                expWrite_t e;
                e = expQ.pop_front();
                checkOutput("wrAddr", 32'(fbAddr), e.addr);
                checkOutput("wrColr", 32'(fbColr), e.colr);
            end
        end
    end

    initial begin
        vector_t vecs[12];
        int      baseWrites;
        int      emitted;
        bit      sawOeLow;

        vecs[0]  = '{5,      2,   7,  1'b1, 645};
        vecs[1]  = '{0,      0,   1,  1'b1, 0};
        vecs[2]  = '{319,    179, 2,  1'b1, 57599};
        vecs[3]  = '{320,    0,   3,  1'b0, 0};
        vecs[4]  = '{-1,     5,   4,  1'b0, 0};
        vecs[5]  = '{0,      180, 5,  1'b0, 0};
        vecs[6]  = '{10,     -1,  6,  1'b0, 0};
        vecs[7]  = '{100,    100, 9,  1'b1, 32100};
        vecs[8]  = '{319,    0,   10, 1'b1, 319};
        vecs[9]  = '{0,      179, 11, 1'b1, 57280};
        vecs[10] = '{-32768, 0,   12, 1'b0, 0};
        vecs[11] = '{1,      1,   15, 1'b1, 321};

        rstN     = 1'b0;
        drawing  = 1'b0;
        drawBusy = 1'b0;
        drawDone = 1'b0;
        fbReady  = 1'b1;
        x        = '0;
        y        = '0;
        colr     = '0;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("rstOe", 32'(oe), 32'd1);
        checkOutput("rstFbWe", 32'(fbWe), 32'd0);
        checkOutput("rstFbAddr", 32'(fbAddr), 32'd0);
        checkOutput("rstFbColr", 32'(fbColr), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstOverflow", 32'(overflow), 32'd0);
        tick();

        // Single pixel latency
        $display("[TB] single pixel latency");
        begin
            expWrite_t e;
            drawBusy = 1'b1;
            x = 16'sd5; y = 16'sd2; colr = 4'd7; drawing = 1'b1;
            e.addr = 645; e.colr = 7;
            expQ.push_back(e);
            tick();
            drawing = 1'b0;
            @(negedge clk);
            checkOutput("lat1FbWe", 32'(fbWe), 32'd0);
            @(negedge clk);
            checkOutput("lat2FbWe", 32'(fbWe), 32'd0);
            @(negedge clk);
            checkOutput("lat3FbWe", 32'(fbWe), 32'd1);
            checkOutput("lat3FbAddr", 32'(fbAddr), 32'd645);
            checkOutput("lat3FbColr", 32'(fbColr), 32'd7);
            checkOutput("lat3Busy", 32'(busy), 32'd1);
            tick();
            @(negedge clk);
            checkOutput("singleOneWrite", 32'(fbWe), 32'd0);
            tick();
            finishShape("single");
        end

        // Clipping and address table
        $display("[TB] clipping/address table");
        baseWrites = writeCount;
        drawBusy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].px, vecs[i].py, vecs[i].pc, vecs[i].expWr, vecs[i].expAddr);
        end
        finishShape("table");
        checkOutput("tableWrites", 32'(writeCount - baseWrites), 32'd7);
        checkOutput("tableOverflow", 32'(overflow), 32'd0);

        // Span crossing the left edge
        $display("[TB] span x=-3..3 y=0");
        baseWrites = writeCount;
        drawBusy = 1'b1;
        for (int i = -3; i <= 3; i++) begin
            applyStimulus(i, 0, 6, (i >= 0), i);
        end
        finishShape("span");
        checkOutput("spanWrites", 32'(writeCount - baseWrites), 32'd4);
        checkOutput("spanOverflow", 32'(overflow), 32'd0);

        // Fully off-screen spans
        $display("[TB] off-screen spans");
        baseWrites = writeCount;
        drawBusy = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(i, 180, 1, 1'b0, 0);
        for (int i = 320; i <= 325; i++) applyStimulus(i, 10, 1, 1'b0, 0);
        finishShape("offscreen");
        checkOutput("offscreenWrites", 32'(writeCount - baseWrites), 32'd0);

        // draw_busy and draw_done together from IDLE
        $display("[TB] busy and done in same cycle");
        drawBusy = 1'b1;
        drawDone = 1'b1;
        tick();
        drawBusy = 1'b0;
        drawDone = 1'b0;
        waitForDone("busyDoneSame");

        // Drawer honouring oe with the framebuffer stalled
        $display("[TB] backpressure with oe throttling");
        baseWrites = writeCount;
        emitted    = 0;
        sawOeLow   = 1'b0;
        fbReady    = 1'b0;
        drawBusy   = 1'b1;
        for (int cyc = 0; cyc < 200 && emitted < 20; cyc++) begin
            if (cyc == 15) fbReady = 1'b1;
            if (!oe) sawOeLow = 1'b1;
            if (oe) begin
                expWrite_t e;
                x       = 16'(emitted);
                y       = 16'sd3;
                colr    = 4'(emitted);
                drawing = 1'b1;
                e.addr  = 960 + emitted;
                e.colr  = emitted % 16;
                expQ.push_back(e);
                emitted++;
            end else begin
                drawing = 1'b0;
            end
            tick();
        end
        drawing = 1'b0;
        checkOutput("bpEmitted", 32'(emitted), 32'd20);
        checkOutput("bpSawOeLow", 32'(sawOeLow), 32'd1);
        finishShape("backpressure");
        checkOutput("bpWrites", 32'(writeCount - baseWrites), 32'd20);
        checkOutput("bpOverflow", 32'(overflow), 32'd0);

        // Drawer ignoring oe: first eight kept, rest dropped
        $display("[TB] drawer ignoring oe");
        baseWrites = writeCount;
        fbReady  = 1'b0;
        drawBusy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i, 4, i % 16, (i < 8), 1280 + i);
        end
        drawing = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("ignOverflow", 32'(overflow), 32'd1);
        checkOutput("ignFbWe", 32'(fbWe), 32'd1);
        checkOutput("ignHeadAddr", 32'(fbAddr), 32'd1280);
        checkOutput("ignHeadColr", 32'(fbColr), 32'd0);
        tick();
        fbReady = 1'b1;
        finishShape("ignoreOe");
        checkOutput("ignWrites", 32'(writeCount - baseWrites), 32'd8);
        checkOutput("ignOverflowSticky", 32'(overflow), 32'd1);

        // Reset in the middle of a shape with entries queued
        $display("[TB] reset mid-span");
        fbReady  = 1'b0;
        drawBusy = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(i, 5, 3, 1'b0, 0);
        drawing = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("preResetFbWe", 32'(fbWe), 32'd1);
        tick();
        rstN     = 1'b0;
        drawBusy = 1'b0;
        tick();
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("postRstFbWe", 32'(fbWe), 32'd0);
        checkOutput("postRstBusy", 32'(busy), 32'd0);
        checkOutput("postRstOe", 32'(oe), 32'd1);
        checkOutput("postRstOverflow", 32'(overflow), 32'd0);
        tick();
        baseWrites = writeCount;
        fbReady = 1'b1;
        repeat (12) tick();
        checkOutput("postRstNoStale", 32'(writeCount - baseWrites), 32'd0);
        checkOutput("postRstQueue", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
